// File: rtl/chan_mux_seq_pkg.sv
// chan_mux_pkg: mode constants, handshake states and default-word helper
package chan_mux_pkg;
  localparam logic MODE_MANUAL = 1'b0;
  localparam logic MODE_SCAN = 1'b1;
  typedef enum logic {EMPTY, FULL} state_t;
  function automatic logic [63:0] all_ones(input int w);
    return (w >= 64) ? '1 : (64'd1 << w) - 64'd1;
  endfunction
endpackage

// File: rtl/chan_mux_seq_scan_ctr.sv
// chan_scan_ctr: dwell counter and wrapping channel counter, cleared on a manual->scan edge
module chan_scan_ctr import chan_mux_pkg::*; #(
  parameter int NCH = 4,
  parameter int SELW = 4,
  parameter int DWELL = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            mode_i,
  input  logic            step_i,
  output logic [SELW-1:0] scan_ch_o
);
  localparam int CW = $clog2(DWELL + 1);
  logic mode_q, clr, wrap;
  logic [SELW-1:0] ch_q, ch_b, ch_d;
  logic [CW-1:0] cnt_q, cnt_b, cnt_d;
  // the edge clears the counters combinationally so an accept on that edge sees channel 0
  always_comb begin
    clr = (mode_i == MODE_SCAN) && (mode_q == MODE_MANUAL);
    ch_b = clr ? '0 : ch_q;
    cnt_b = clr ? '0 : cnt_q;
    wrap = cnt_b == CW'(DWELL - 1);
    cnt_d = step_i ? (wrap ? '0 : cnt_b + 1'b1) : cnt_b;
    ch_d = (step_i && wrap) ? ((ch_b == SELW'(NCH - 1)) ? '0 : ch_b + 1'b1) : ch_b;
    scan_ch_o = ch_b;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      mode_q <= MODE_MANUAL;
      ch_q <= '0;
      cnt_q <= '0;
    end else begin
      mode_q <= mode_i;
      ch_q <= ch_d;
      cnt_q <= cnt_d;
    end
endmodule

// File: rtl/chan_mux_seq.sv
// chan_mux_seq: registered N-channel word selector with valid/ready handshake and scan mode
module chan_mux_seq import chan_mux_pkg::*; #(
  parameter int WIDTH = 4,
  parameter int NCH = 4,
  parameter int SELW = 4,
  parameter logic [WIDTH-1:0] DEFAULT = WIDTH'(all_ones(WIDTH)),
  parameter int DWELL = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NCH*WIDTH-1:0] din_i,
  input  logic [SELW-1:0]    sel_i,
  input  logic               mode_i,
  input  logic               in_valid_i,
  output logic               in_ready_o,
  output logic [WIDTH-1:0]   out_data_o,
  output logic [SELW-1:0]    out_ch_o,
  output logic               out_err_o,
  output logic               out_valid_o,
  input  logic               out_ready_i
);
  state_t state_q;
  logic acc, hit_d;
  logic [SELW-1:0] scan_ch, ch_d;
  logic [WIDTH-1:0] word_d;
  assign out_valid_o = state_q == FULL;
  assign in_ready_o = !out_valid_o || out_ready_i;
  assign acc = in_valid_i && in_ready_o;
  chan_scan_ctr #(.NCH(NCH), .SELW(SELW), .DWELL(DWELL)) u_scan (
    .clk(clk),
    .rst_n(rst_n),
    .mode_i(mode_i),
    .step_i(acc && (mode_i == MODE_SCAN)),
    .scan_ch_o(scan_ch)
  );
  always_comb begin
    ch_d = (mode_i == MODE_SCAN) ? scan_ch : sel_i;
    word_d = DEFAULT;
    hit_d = 1'b0;
    for (int k = 0; k < NCH; k++)
      if (ch_d == SELW'(k)) begin
        word_d = din_i[k*WIDTH +: WIDTH];
        hit_d = 1'b1;
      end
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= EMPTY;
      out_data_o <= DEFAULT;
      out_ch_o <= '0;
      out_err_o <= 1'b0;
    end else if (acc) begin
      state_q <= FULL;
      out_data_o <= word_d;
      out_ch_o <= ch_d;
      out_err_o <= !hit_d;
    end else if (out_ready_i)
      state_q <= EMPTY;
endmodule

// File: tb/tb_chan_mux_seq.sv
// tb_chan_mux_seq: directed and randomized checks against a transfer-count reference model
module tb_chan_mux_seq;
  localparam int WIDTH = 4, NCH = 4, SELW = 4, DWELL = 2;
  logic clk = 0, rst_n = 0, run = 1;
  logic [NCH*WIDTH-1:0] din_i = '0;
  logic [SELW-1:0] sel_i = '0;
  logic mode_i = 0, in_valid_i = 0, out_ready_i = 1;
  logic in_ready_o, out_err_o, out_valid_o;
  logic [WIDTH-1:0] out_data_o;
  logic [SELW-1:0] out_ch_o;
  int checks = 0, failures = 0;
  logic m_valid, m_err, m_mode_prev;
  logic [WIDTH-1:0] m_data;
  int m_ch, n;
  int scan_exp [10] = '{0, 0, 1, 1, 2, 2, 3, 3, 0, 0};

  chan_mux_seq #(.WIDTH(WIDTH), .NCH(NCH), .SELW(SELW), .DWELL(DWELL)) dut (
    .clk(clk), .rst_n(rst_n), .din_i(din_i), .sel_i(sel_i), .mode_i(mode_i),
    .in_valid_i(in_valid_i), .in_ready_o(in_ready_o), .out_data_o(out_data_o),
    .out_ch_o(out_ch_o), .out_err_o(out_err_o), .out_valid_o(out_valid_o),
    .out_ready_i(out_ready_i)
  );

  initial forever begin
    #5;
    if (run) clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic mreset();
    m_valid = 0; m_data = 4'hf; m_ch = 0; m_err = 0; n = 0; m_mode_prev = 0;
  endtask

  task automatic check_out();
    chk("out_valid", out_valid_o, m_valid);
    chk("out_data", out_data_o, m_data);
    chk("out_ch", out_ch_o, m_ch);
    chk("out_err", out_err_o, m_err);
  endtask

  // scan channel = (scan accepts since the last manual->scan rise / DWELL) mod NCH
  task automatic step();
    logic acc;
    int ch;
    #1;
    chk("in_ready", in_ready_o, !m_valid || out_ready_i);
    if (mode_i && !m_mode_prev) n = 0;
    acc = in_valid_i && (!m_valid || out_ready_i);
    if (acc) begin
      if (mode_i) begin
        ch = (n / DWELL) % NCH;
        n++;
      end else ch = int'(sel_i);
      m_ch = ch;
      m_err = ch >= NCH;
      m_data = (ch < NCH) ? din_i[ch*WIDTH +: WIDTH] : 4'hf;
      m_valid = 1;
    end else if (out_ready_i) m_valid = 0;
    m_mode_prev = mode_i;
    @(posedge clk);
    #1;
    check_out();
  endtask

  initial begin
    mreset();
    repeat (2) @(posedge clk);
    #1;
    check_out();
    rst_n = 1;
    step();
    din_i = 16'hdaeb;
    in_valid_i = 1;
    for (int s = 0; s < 16; s++) begin
      sel_i = SELW'(s);
      step();
    end
    sel_i = 1;
    step();
    chk("bp_word", out_data_o, 4'he);
    out_ready_i = 0;
    for (int i = 0; i < 5; i++) begin
      sel_i = SELW'($urandom);
      din_i = 16'($urandom);
      step();
      chk("bp_frozen", out_data_o, 4'he);
    end
    out_ready_i = 1;
    din_i = 16'hdaeb;
    sel_i = 2;
    step();
    chk("no_bubble", {out_valid_o, out_data_o}, {1'b1, 4'ha});
    mode_i = 1;
    for (int i = 0; i < 10; i++) begin
      step();
      chk("scan_seq", out_ch_o, scan_exp[i]);
    end
    repeat (3) step();
    chk("scan_at_ch2", out_ch_o, 2);
    mode_i = 0;
    repeat (3) begin
      sel_i = SELW'($urandom);
      step();
    end
    mode_i = 1;
    step();
    chk("mode_edge_ch0", out_ch_o, 0);
    for (int i = 0; i < 300; i++) begin
      in_valid_i = 1'($urandom);
      out_ready_i = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 7) == 0) mode_i = ~mode_i;
      sel_i = SELW'($urandom);
      din_i = 16'($urandom);
      step();
    end
    mode_i = 0;
    in_valid_i = 1;
    out_ready_i = 0;
    sel_i = 3;
    step();
    step();
    chk("full_before_rst", out_valid_o, 1);
    run = 0;
    #20;
    rst_n = 0;
    #3;
    mreset();
    chk("arst_valid", out_valid_o, 0);
    chk("arst_data", out_data_o, 4'hf);
    chk("arst_ch", out_ch_o, 0);
    #3;
    rst_n = 1;
    #3;
    run = 1;
    out_ready_i = 1;
    sel_i = 2;
    din_i = 16'hdaeb;
    step();
    chk("post_rst_word", out_data_o, 4'ha);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
